// File: rtl/wishbone_pkg.sv
// Shared types and constants for the Wishbone arbiter slice.
//   arb_state_t : arbiter ownership state (IDLE / OWNED)
//   WB_DW       : Wishbone data/address width
//   WB_SW       : byte-select width derived from WB_DW
package wishbone_pkg;

  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = WB_DW / 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

endpackage : wishbone_pkg

// File: rtl/wishbone_rr_picker.sv
// Combinational round-robin picker.
// Scans the request vector starting at last_i+1 (wrapping) and returns the
// first requester found.
//   req_i    : per-master request (cyc) vector
//   last_i   : index of the most recent winner
//   winner_o : index of the selected master (0 when none)
//   valid_o  : high when at least one master is requesting
module wishbone_rr_picker #(
  parameter int unsigned MASTERS = 2,
  parameter int unsigned IW      = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic [MASTERS-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [IW-1:0]      winner_o,
  output logic               valid_o
);

  logic [IW-1:0] cand;

  // Lowest offset from last_i+1 wins, so the previous winner is considered last.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= MASTERS; k++) begin
      cand = IW'((32'(last_i) + k) % MASTERS);
      if (!valid_o && req_i[cand]) begin
        valid_o  = 1'b1;
        winner_o = cand;
      end
    end
  end

endmodule : wishbone_rr_picker

// File: rtl/wishbone_arbiter.sv
// Round-robin Wishbone arbiter: shares one bus master port among MASTERS
// requesters, holding the grant for a whole cyc tenure, with a per-transfer
// watchdog that converts a silent slave into a bus error.
//   sysClk, sysRst          : clock, synchronous active-high reset
//   wb_*_m (inputs)         : per-master cyc/stb/we/sel/adr/dat_o
//   wb_ack/err/stall/dat_i_m: per-master responses (owner only; others stall)
//   wb_*_b (outputs)        : muxed request to the bus
//   wb_ack/err/stall/dat_i_b: responses from the bus
//   grant                   : one-hot current owner, zero when idle
module wishbone_arbiter
  import wishbone_pkg::*;
#(
  parameter int unsigned MASTERS = 2,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                            sysClk,
  input  logic                            sysRst,
  input  logic [MASTERS-1:0]              wb_cyc_m,
  input  logic [MASTERS-1:0]              wb_stb_m,
  input  logic [MASTERS-1:0]              wb_we_m,
  input  logic [MASTERS-1:0][WB_SW-1:0]   wb_sel_m,
  input  logic [MASTERS-1:0][WB_DW-1:0]   wb_adr_m,
  input  logic [MASTERS-1:0][WB_DW-1:0]   wb_dat_o_m,
  output logic [MASTERS-1:0]              wb_ack_m,
  output logic [MASTERS-1:0]              wb_err_m,
  output logic [MASTERS-1:0]              wb_stall_m,
  output logic [MASTERS-1:0][WB_DW-1:0]   wb_dat_i_m,
  output logic                            wb_cyc_b,
  output logic                            wb_stb_b,
  output logic                            wb_we_b,
  output logic [WB_SW-1:0]                wb_sel_b,
  output logic [WB_DW-1:0]                wb_adr_b,
  output logic [WB_DW-1:0]                wb_dat_o_b,
  input  logic                            wb_ack_b,
  input  logic                            wb_err_b,
  input  logic                            wb_stall_b,
  input  logic [WB_DW-1:0]                wb_dat_i_b,
  output logic [MASTERS-1:0]              grant
);

  localparam int unsigned IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q,  last_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          owned;
  logic          own_cyc;
  logic          own_stb;
  logic          wd_hit;
  logic          wd_err;

  wishbone_rr_picker #(
    .MASTERS (MASTERS),
    .IW      (IW)
  ) u_picker (
    .req_i    (wb_cyc_m),
    .last_i   (last_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  // Owner view and watchdog terminal count.
  always_comb begin
    owned   = (state_q == OWNED);
    own_cyc = wb_cyc_m[owner_q];
    own_stb = wb_stb_m[owner_q];
    wd_hit  = owned && own_stb && (cnt_q == CW'(TIMEOUT - 1));
    // A real response in the terminal cycle takes precedence over the timeout.
    wd_err  = wd_hit && !wb_ack_b && !wb_err_b;
  end

  // Next-state: arbitration, release and watchdog counting.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWNED;
          owner_d = pick_idx;
          last_d  = pick_idx;
        end
      end
      OWNED: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!owned || !own_stb || wb_ack_b || wb_err_b || wd_hit) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers; last resets to MASTERS-1 so master 0 wins first.
  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request mux to the bus; stb is withheld in the watchdog terminal cycle.
  always_comb begin
    wb_cyc_b   = 1'b0;
    wb_stb_b   = 1'b0;
    wb_we_b    = 1'b0;
    wb_sel_b   = '0;
    wb_adr_b   = '0;
    wb_dat_o_b = '0;
    if (owned) begin
      wb_cyc_b   = own_cyc;
      wb_stb_b   = own_stb && !wd_hit;
      wb_we_b    = wb_we_m[owner_q];
      wb_sel_b   = wb_sel_m[owner_q];
      wb_adr_b   = wb_adr_m[owner_q];
      wb_dat_o_b = wb_dat_o_m[owner_q];
    end
  end

  // Response demux: only the owner sees the bus; everyone else is stalled.
  always_comb begin
    grant      = '0;
    wb_ack_m   = '0;
    wb_err_m   = '0;
    wb_stall_m = wb_stb_m;
    wb_dat_i_m = '0;
    if (owned) begin
      grant[owner_q]      = 1'b1;
      wb_ack_m[owner_q]   = wb_ack_b;
      wb_err_m[owner_q]   = wb_err_b || wd_err;
      wb_stall_m[owner_q] = wb_stall_b;
      wb_dat_i_m[owner_q] = wb_dat_i_b;
    end
  end

endmodule : wishbone_arbiter

// File: tb/tb_wishbone_arbiter.sv
// Directed self-checking bench for wishbone_arbiter (MASTERS=2, TIMEOUT=8).
module tb_wishbone_arbiter;

  logic              sysClk;
  logic              sysRst;
  logic [1:0]        wb_cyc_m;
  logic [1:0]        wb_stb_m;
  logic [1:0]        wb_we_m;
  logic [1:0][3:0]   wb_sel_m;
  logic [1:0][31:0]  wb_adr_m;
  logic [1:0][31:0]  wb_dat_o_m;
  logic [1:0]        wb_ack_m;
  logic [1:0]        wb_err_m;
  logic [1:0]        wb_stall_m;
  logic [1:0][31:0]  wb_dat_i_m;
  logic              wb_cyc_b;
  logic              wb_stb_b;
  logic              wb_we_b;
  logic [3:0]        wb_sel_b;
  logic [31:0]       wb_adr_b;
  logic [31:0]       wb_dat_o_b;
  logic              wb_ack_b;
  logic              wb_err_b;
  logic              wb_stall_b;
  logic [31:0]       wb_dat_i_b;
  logic [1:0]        grant;

  int n_chk;
  int n_fail;

  wishbone_arbiter #(
    .MASTERS (2),
    .TIMEOUT (8)
  ) dut (
    .sysClk     (sysClk),
    .sysRst     (sysRst),
    .wb_cyc_m   (wb_cyc_m),
    .wb_stb_m   (wb_stb_m),
    .wb_we_m    (wb_we_m),
    .wb_sel_m   (wb_sel_m),
    .wb_adr_m   (wb_adr_m),
    .wb_dat_o_m (wb_dat_o_m),
    .wb_ack_m   (wb_ack_m),
    .wb_err_m   (wb_err_m),
    .wb_stall_m (wb_stall_m),
    .wb_dat_i_m (wb_dat_i_m),
    .wb_cyc_b   (wb_cyc_b),
    .wb_stb_b   (wb_stb_b),
    .wb_we_b    (wb_we_b),
    .wb_sel_b   (wb_sel_b),
    .wb_adr_b   (wb_adr_b),
    .wb_dat_o_b (wb_dat_o_b),
    .wb_ack_b   (wb_ack_b),
    .wb_err_b   (wb_err_b),
    .wb_stall_b (wb_stall_b),
    .wb_dat_i_b (wb_dat_i_b),
    .grant      (grant)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  // Move to the falling edge (sample point).
  task automatic settle();
    @(negedge sysClk);
  endtask

  task automatic reset_dut();
    sysRst = 1'b1;
    tick();
    sysRst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    sysRst     = 1'b1;
    wb_cyc_m   = '0;
    wb_stb_m   = '0;
    wb_we_m    = '0;
    wb_sel_m   = '0;
    wb_adr_m   = '0;
    wb_dat_o_m = '0;
    wb_ack_b   = 1'b0;
    wb_err_b   = 1'b0;
    wb_stall_b = 1'b0;
    wb_dat_i_b = '0;
    tick();
    wb_stb_m = 2'b10;
    tick();

    // Reset state
    settle();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_cyc_b", 32'(wb_cyc_b), 32'h0);
    chk("rst_stb_b", 32'(wb_stb_b), 32'h0);
    chk("rst_adr_b", wb_adr_b, 32'h0);
    chk("rst_ack_m", 32'(wb_ack_m), 32'h0);
    chk("rst_err_m", 32'(wb_err_m), 32'h0);
    chk("rst_stall_m", 32'(wb_stall_m), 32'h2);
    tick();
    sysRst   = 1'b0;
    wb_stb_m = '0;

    // Single master write to 0x10, ack two cycles after grant
    wb_cyc_m[0]   = 1'b1;
    wb_stb_m[0]   = 1'b1;
    wb_we_m[0]    = 1'b1;
    wb_sel_m[0]   = 4'hF;
    wb_adr_m[0]   = 32'h10;
    wb_dat_o_m[0] = 32'hDEAD_BEEF;
    wb_adr_m[1]   = 32'h20;
    wb_dat_o_m[1] = 32'h5555_AAAA;
    settle();
    chk("s_pre_grant", 32'(grant), 32'h0);
    tick();
    settle();
    chk("s_grant", 32'(grant), 32'h1);
    chk("s_cyc_b", 32'(wb_cyc_b), 32'h1);
    chk("s_stb_b", 32'(wb_stb_b), 32'h1);
    chk("s_we_b", 32'(wb_we_b), 32'h1);
    chk("s_sel_b", 32'(wb_sel_b), 32'hF);
    chk("s_adr_b", wb_adr_b, 32'h10);
    chk("s_dat_b", wb_dat_o_b, 32'hDEAD_BEEF);
    chk("s_noack", 32'(wb_ack_m), 32'h0);
    tick();
    wb_ack_b   = 1'b1;
    wb_dat_i_b = 32'h1234_5678;
    settle();
    chk("s_ack_m", 32'(wb_ack_m), 32'h1);
    chk("s_err_m", 32'(wb_err_m), 32'h0);
    chk("s_dat_m0", wb_dat_i_m[0], 32'h1234_5678);
    chk("s_dat_m1", wb_dat_i_m[1], 32'h0);
    tick();
    wb_ack_b    = 1'b0;
    wb_dat_i_b  = '0;
    wb_cyc_m[0] = 1'b0;
    wb_stb_m[0] = 1'b0;
    settle();
    chk("s_rel_grant", 32'(grant), 32'h1);
    chk("s_rel_cyc_b", 32'(wb_cyc_b), 32'h0);
    tick();
    settle();
    chk("s_idle_grant", 32'(grant), 32'h0);
    tick();

    // Contention straight after reset
    reset_dut();
    wb_cyc_m = 2'b11;
    wb_stb_m = 2'b11;
    settle();
    chk("c_idle_stall", 32'(wb_stall_m), 32'h3);
    tick();
    settle();
    chk("c_grant0", 32'(grant), 32'h1);
    chk("c_stall", 32'(wb_stall_m), 32'h2);
    chk("c_adr0", wb_adr_b, 32'h10);
    tick();
    settle();
    chk("c_hold", 32'(grant), 32'h1);
    tick();
    wb_cyc_m[0] = 1'b0;
    wb_stb_m[0] = 1'b0;
    tick();
    settle();
    chk("c_gap", 32'(grant), 32'h0);
    chk("c_gap_stall", 32'(wb_stall_m), 32'h2);
    tick();
    settle();
    chk("c_grant1", 32'(grant), 32'h2);
    chk("c_adr1", wb_adr_b, 32'h20);
    tick();
    wb_cyc_m[1] = 1'b0;
    wb_stb_m[1] = 1'b0;
    tick();

    // Fairness: both masters always requesting, one transfer per tenure
    wb_cyc_m = 2'b11;
    wb_stb_m = 2'b11;
    for (int t = 0; t < 4; t++) begin
      logic [1:0] exp_g;
      int         o;
      bit         seen;
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      o     = (t % 2 == 0) ? 0 : 1;
      seen  = 1'b0;
      for (int w = 0; w < 6 && !seen; w++) begin
        settle();
        if (grant != 2'b00) seen = 1'b1;
        else tick();
      end
      chk("f_wait", 32'(seen), 32'h1);
      chk($sformatf("f_grant%0d", t), 32'(grant), 32'(exp_g));
      tick();
      wb_ack_b = 1'b1;
      tick();
      wb_ack_b    = 1'b0;
      wb_cyc_m[o] = 1'b0;
      wb_stb_m[o] = 1'b0;
      tick();
      if (t < 3) begin
        wb_cyc_m[o] = 1'b1;
        wb_stb_m[o] = 1'b1;
      end else begin
        wb_cyc_m = '0;
        wb_stb_m = '0;
      end
    end
    tick();

    // Watchdog: silent slave, error on cycle 8 and again on cycle 16
    wb_cyc_m[0] = 1'b1;
    wb_stb_m[0] = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      settle();
      chk($sformatf("w_err_c%0d", c), 32'(wb_err_m), (c % 8 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("w_stb_c%0d", c), 32'(wb_stb_b), (c % 8 == 0) ? 32'h0 : 32'h1);
      tick();
    end
    wb_cyc_m[0] = 1'b0;
    wb_stb_m[0] = 1'b0;
    tick();
    tick();

    // Ack in the watchdog terminal cycle wins over the timeout
    wb_cyc_m[0] = 1'b1;
    wb_stb_m[0] = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      if (c == 8) wb_ack_b = 1'b1;
      settle();
      if (c == 8) begin
        chk("x_ack", 32'(wb_ack_m), 32'h1);
        chk("x_noerr", 32'(wb_err_m), 32'h0);
      end
      tick();
    end
    wb_ack_b = 1'b0;
    settle();
    chk("x_after_err", 32'(wb_err_m), 32'h0);
    chk("x_after_stb", 32'(wb_stb_b), 32'h1);
    tick();
    wb_cyc_m[0] = 1'b0;
    wb_stb_m[0] = 1'b0;
    tick();
    tick();

    // Reset during the third beat of an M1 burst
    wb_cyc_m[1] = 1'b1;
    wb_stb_m[1] = 1'b1;
    wb_ack_b    = 1'b1;
    tick();
    settle();
    chk("r_grant", 32'(grant), 32'h2);
    chk("r_ack", 32'(wb_ack_m), 32'h2);
    tick();
    tick();
    sysRst = 1'b1;
    tick();
    settle();
    chk("r_rst_grant", 32'(grant), 32'h0);
    chk("r_rst_cyc_b", 32'(wb_cyc_b), 32'h0);
    chk("r_rst_ack", 32'(wb_ack_m), 32'h0);
    tick();
    sysRst      = 1'b0;
    wb_ack_b    = 1'b0;
    wb_cyc_m[1] = 1'b0;
    wb_stb_m[1] = 1'b0;
    tick();
    wb_cyc_m = 2'b11;
    wb_stb_m = 2'b11;
    settle();
    chk("r_pre", 32'(grant), 32'h0);
    tick();
    settle();
    chk("r_m0_wins", 32'(grant), 32'h1);
    tick();
    wb_cyc_m = '0;
    wb_stb_m = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_wishbone_arbiter
